// File: rtl/l1cache_pkg.sv
// Shared types and constants for the N-way L1 cache.
package l1cache_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned BLOCK_W = WORD_W * WORDS;

    // One cache block viewed as four 32-bit words; word 0 is the low 32 bits
    typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBACK = 2'd1,
        ALLOC = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lru_tracker.sv
// Per-set true-LRU age tracking; age 0 = most recent, WAYS-1 = oldest.
module lru_tracker
    import l1cache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 4,
    localparam int unsigned IDX_W = clog2(SETS),
    localparam int unsigned WAY_W = (WAYS > 1) ? clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way,
    input  logic [IDX_W-1:0] qry_set,
    output logic [WAY_W-1:0] oldest_way_c
);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];

    // Touched way becomes youngest; ways younger than its old age get one older
    always_comb begin
        age_d = age_q;
        if (upd_en) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == upd_way) begin
                    age_d[upd_set][WAY_W'(w)] = '0;
                end else if (age_q[upd_set][WAY_W'(w)] < age_q[upd_set][upd_way]) begin
                    age_d[upd_set][WAY_W'(w)] = age_q[upd_set][WAY_W'(w)] + 1'b1;
                end
            end
        end
    end

    // Age registers; reset gives each way an age equal to its index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[IDX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    // Oldest way of the queried set
    always_comb begin
        oldest_way_c = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[qry_set][WAY_W'(w)] == WAY_W'(WAYS - 1)) begin
                oldest_way_c = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/l1cache_nway.sv
// N-way set-associative write-back, write-allocate L1 cache with true LRU.
module l1cache_nway
    import l1cache_pkg::*;
#(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 4,
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               clk,
    input  logic               proc_reset,
    input  logic               proc_read,
    input  logic               proc_write,
    input  logic [ADDR_W-1:0]  proc_addr,
    input  logic [WORD_W-1:0]  proc_wdata,
    output logic               proc_stall,
    output logic [WORD_W-1:0]  proc_rdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-3:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic [CNT_W-1:0]   access_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int unsigned IDX_W = clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    block_t            data_q  [SETS][WAYS];
    block_t            data_d  [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-1:0]   dirty_d [SETS];

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    block_t            mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  access_cnt_q, access_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  tag_c;
    logic [IDX_W-1:0]  idx_c;
    logic [OFF_W-1:0]  word_c;
    logic              req_c, hit_c, done_c, inv_found_c;
    logic [WAY_W-1:0]  hit_way_c, victim_c, lru_way_c;

    assign tag_c  = proc_addr[ADDR_W-1:IDX_W+OFF_W];
    assign idx_c  = proc_addr[IDX_W+OFF_W-1:OFF_W];
    assign word_c = proc_addr[OFF_W-1:0];
    assign req_c  = proc_read | proc_write;

    lru_tracker #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk          (clk),
        .rst          (proc_reset),
        .upd_en       (done_c),
        .upd_set      (idx_c),
        .upd_way      (hit_way_c),
        .qry_set      (idx_c),
        .oldest_way_c (lru_way_c)
    );

    // Tag lookup and victim choice: lowest invalid way, else the LRU way
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        victim_c    = lru_way_c;
        inv_found_c = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx_c][w] && (tag_q[idx_c][WAY_W'(w)] == tag_c)) begin
                hit_c     = req_c;
                hit_way_c = WAY_W'(w);
            end
            if (!inv_found_c && !valid_q[idx_c][w]) begin
                victim_c    = WAY_W'(w);
                inv_found_c = 1'b1;
            end
        end
    end

    assign proc_stall = req_c && !((state_q == IDLE) && hit_c);
    assign done_c     = req_c && !proc_stall;
    assign proc_rdata = data_q[idx_c][hit_way_c][word_c];

    // Next state: hit completion, miss handling FSM and counters
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        access_cnt_d = access_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        tag_d        = tag_q;
        data_d       = data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;

        if (done_c) begin
            if (access_cnt_q != '1) begin
                access_cnt_d = access_cnt_q + 1'b1;
            end
            if (proc_write) begin
                data_d[idx_c][hit_way_c][word_c] = proc_wdata;
                dirty_d[idx_c][hit_way_c]        = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (req_c && !hit_c) begin
                    victim_d = victim_c;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                    if (dirty_q[idx_c][victim_c]) begin
                        state_d     = WBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[idx_c][victim_c], idx_c};
                        mem_wdata_d = data_q[idx_c][victim_c];
                    end else begin
                        state_d    = ALLOC;
                        mem_read_d = 1'b1;
                        mem_addr_d = proc_addr[ADDR_W-1:OFF_W];
                    end
                end
            end
            WBACK: begin
                if (mem_ready) begin
                    state_d     = ALLOC;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[ADDR_W-1:OFF_W];
                end
            end
            ALLOC: begin
                if (mem_ready) begin
                    state_d                  = IDLE;
                    mem_read_d               = 1'b0;
                    data_d[idx_c][victim_q]  = mem_rdata;
                    tag_d[idx_c][victim_q]   = tag_c;
                    valid_d[idx_c][victim_q] = 1'b1;
                    dirty_d[idx_c][victim_q] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, status and counter registers
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IDX_W'(s)] <= '0;
                dirty_q[IDX_W'(s)] <= '0;
            end
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Tag and data storage; contents are qualified by valid, so no reset
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign access_cnt = access_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_l1cache_nway.sv
// Directed bench for l1cache_nway (2 ways, 4 sets, 3-bit counters, 3-cycle memory).
module tb_l1cache_nway;

    localparam int unsigned LAT = 3;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [2:0]   access_cnt;
    logic [2:0]   miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    l1cache_nway #(
        .WAYS   (2),
        .SETS   (4),
        .ADDR_W (30),
        .CNT_W  (3)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .access_cnt (access_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: untouched blocks read back as word k = {block_addr, k}
    logic [127:0] mem_img [logic [27:0]];
    int           lat_cnt = 0;
    int           rf_cnt = 0;
    int           wb_cnt = 0;
    int           both_hi = 0;
    logic [27:0]  last_rf_addr = '0;
    logic [27:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;

    function automatic logic [127:0] rd_block(input logic [27:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a, 4'd3, a, 4'd2, a, 4'd1, a, 4'd0};
    endfunction

    always @(posedge clk) begin
        if (mem_read && mem_write) both_hi++;
        if (proc_reset) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
        end else if (mem_read || mem_write) begin
            if (lat_cnt == int'(LAT) - 2) begin
                mem_ready <= 1'b1;
                if (mem_write) begin
                    mem_img[mem_addr] = mem_wdata;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                    wb_cnt++;
                end else begin
                    mem_rdata    <= rd_block(mem_addr);
                    last_rf_addr = mem_addr;
                    rf_cnt++;
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One processor request; returns stall cycles and read data at completion
    task automatic do_req(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rd);
        @(negedge clk);
        proc_read  = !wr;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        stalls     = 0;
        #1;
        while (proc_stall && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        rd = proc_rdata;
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        int          rf0;
        int          wb0;

        repeat (3) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        check_eq("rst_stall", 128'(proc_stall), 128'd0);
        check_eq("rst_mem_read", 128'(mem_read), 128'd0);
        check_eq("rst_mem_write", 128'(mem_write), 128'd0);
        check_eq("rst_access_cnt", 128'(access_cnt), 128'd0);
        check_eq("rst_miss_cnt", 128'(miss_cnt), 128'd0);

        // Cold read miss of word 0x10 (block 0x4)
        do_req(1'b0, 30'h10, 32'h0, st, rd);
        check_eq("cold_stalls", 128'(st), 128'd4);
        check_eq("cold_rf_addr", 128'(last_rf_addr), 128'h4);
        check_eq("cold_rdata", 128'(rd), 128'h40);
        check_eq("cold_miss_cnt", 128'(miss_cnt), 128'd1);
        check_eq("cold_access_cnt", 128'(access_cnt), 128'd1);

        // Hit write then hit read in the refilled block
        rf0 = rf_cnt;
        wb0 = wb_cnt;
        do_req(1'b1, 30'h11, 32'hDEADBEEF, st, rd);
        check_eq("hitwr_stalls", 128'(st), 128'd0);
        do_req(1'b0, 30'h11, 32'h0, st, rd);
        check_eq("hitrd_stalls", 128'(st), 128'd0);
        check_eq("hitrd_rdata", 128'(rd), 128'hDEADBEEF);
        check_eq("hit_no_mem", 128'((rf_cnt - rf0) + (wb_cnt - wb0)), 128'd0);

        // Clean eviction in set 1: A=0x24, B=0x34, touch A, then C=0x44 evicts B
        do_req(1'b0, 30'h24, 32'h0, st, rd);
        do_req(1'b0, 30'h34, 32'h0, st, rd);
        check_eq("fillB_stalls", 128'(st), 128'd4);
        do_req(1'b0, 30'h24, 32'h0, st, rd);
        check_eq("touchA_stalls", 128'(st), 128'd0);
        wb0 = wb_cnt;
        do_req(1'b0, 30'h44, 32'h0, st, rd);
        check_eq("clean_evict_stalls", 128'(st), 128'd4);
        check_eq("clean_evict_no_wb", 128'(wb_cnt - wb0), 128'd0);
        check_eq("clean_evict_rdata", 128'(rd), 128'h110);
        do_req(1'b0, 30'h24, 32'h0, st, rd);
        check_eq("A_kept_stalls", 128'(st), 128'd0);
        check_eq("A_kept_rdata", 128'(rd), 128'h90);
        do_req(1'b0, 30'h34, 32'h0, st, rd);
        check_eq("B_gone_stalls", 128'(st), 128'd4);

        // Dirty eviction in set 2: write A=0x59, fill B=0x68, miss C=0x78 evicts A
        do_req(1'b1, 30'h59, 32'hCAFEF00D, st, rd);
        check_eq("wr_alloc_stalls", 128'(st), 128'd4);
        do_req(1'b0, 30'h68, 32'h0, st, rd);
        wb0 = wb_cnt;
        do_req(1'b0, 30'h78, 32'h0, st, rd);
        check_eq("dirty_evict_stalls", 128'(st), 128'd7);
        check_eq("dirty_wb_count", 128'(wb_cnt - wb0), 128'd1);
        check_eq("dirty_wb_addr", 128'(last_wb_addr), 128'h16);
        check_eq("dirty_wb_word1", 128'(last_wb_data[63:32]), 128'hCAFEF00D);
        check_eq("dirty_wb_word0", 128'(last_wb_data[31:0]), 128'h160);
        check_eq("dirty_rf_addr", 128'(last_rf_addr), 128'h1E);
        check_eq("dirty_rdata", 128'(rd), 128'h1E0);
        do_req(1'b0, 30'h59, 32'h0, st, rd);
        check_eq("wb_roundtrip_stalls", 128'(st), 128'd4);
        check_eq("wb_roundtrip_rdata", 128'(rd), 128'hCAFEF00D);

        // Reset during write-back in set 3
        do_req(1'b1, 30'h8C, 32'h12345678, st, rd);
        do_req(1'b0, 30'h9C, 32'h0, st, rd);
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'hAC;
        @(negedge clk);
        #1;
        check_eq("wback_active", 128'(mem_write), 128'd1);
        check_eq("wback_addr", 128'(mem_addr), 128'h23);
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        check_eq("midrst_mem_write", 128'(mem_write), 128'd0);
        check_eq("midrst_mem_read", 128'(mem_read), 128'd0);
        check_eq("midrst_stall", 128'(proc_stall), 128'd0);
        check_eq("midrst_access_cnt", 128'(access_cnt), 128'd0);
        do_req(1'b0, 30'h8C, 32'h0, st, rd);
        check_eq("reread_stalls", 128'(st), 128'd4);
        check_eq("reread_rdata", 128'(rd), 128'h230);
        check_eq("reread_miss_cnt", 128'(miss_cnt), 128'd1);

        // Counter saturation at 3'b111
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, 30'(32'h100 + (i << 4)), 32'h0, st, rd);
        end
        check_eq("cnt6_miss", 128'(miss_cnt), 128'd6);
        check_eq("cnt6_access", 128'(access_cnt), 128'd6);
        for (int i = 5; i < 8; i++) begin
            do_req(1'b0, 30'(32'h100 + (i << 4)), 32'h0, st, rd);
        end
        check_eq("sat_miss", 128'(miss_cnt), 128'd7);
        check_eq("sat_access", 128'(access_cnt), 128'd7);

        check_eq("read_write_exclusive", 128'(both_hi), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
